// File: rtl/device_rx_pkg.sv
// Shared types and constants for the remote-terminal receive path.
// Holds the FSM encoding and the response-word field layout.
package device_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CW,
        WAIT_WORD,
        STORE,
        PAUSE_WAIT,
        LOAD_OS,
        SEND_WAIT,
        SEND_OS,
        END_WAIT
    } state_t;

    localparam int RESP_ADDR_MSB   = 15;
    localparam int RESP_ADDR_LSB   = 11;
    localparam int RESP_ERR_BIT    = 10;
    localparam int TX_READY_CYCLES = 3;
    localparam int WORDS_MAX       = 32;

endpackage

// File: rtl/rx_word_ram.sv
// 32x16 received-word store: one write port, one registered read port.
// Contents are not reset; only the read register is.
module rx_word_ram (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [4:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem [32];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/device_rx.sv
// Remote-terminal receive transaction: collects N data words into RAM,
// then sends the status response word after a fixed pause.
module device_rx
    import device_rx_pkg::*;
#(
    parameter logic [4:0] ADDRESS        = 5'd1,
    parameter int         PAUSE_CYCLES   = 255,
    parameter int         TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    input  logic        rx_cd,
    input  logic        p_error,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    output logic        tx_ready,
    input  logic        tx_busy,
    input  logic [4:0]  addr_rd,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        msg_error
);

    localparam logic [15:0] PAUSE_LAST   = 16'(PAUSE_CYCLES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  SEND_LAST    = 2'(TX_READY_CYCLES - 1);

    state_t      state, state_d;
    logic [5:0]  cnt_word;
    logic [5:0]  n_words;
    logic [15:0] cnt_pause;
    logic [15:0] cnt_timeout;
    logic [1:0]  cnt_send;
    logic [15:0] word_q;
    logic        perr_q;
    logic        timeout_hit;
    logic        last_word;
    logic        ram_we;

    assign timeout_hit = (cnt_timeout == TIMEOUT_LAST);
    assign last_word   = ((cnt_word + 6'd1) == n_words);
    assign ram_we      = (state == STORE) && !reset;
    assign tx_ready    = (state == SEND_OS);
    assign busy        = (state != IDLE);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:       state_d = IDLE;
            LOAD_CW:    state_d = WAIT_WORD;
            WAIT_WORD: begin
                if (rx_valid && rx_cd) begin
                    state_d = STORE;
                end else if (rx_valid || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            STORE:      state_d = last_word ? PAUSE_WAIT : WAIT_WORD;
            PAUSE_WAIT: if (cnt_pause == PAUSE_LAST) state_d = LOAD_OS;
            LOAD_OS:    state_d = SEND_WAIT;
            SEND_WAIT:  if (!tx_busy) state_d = SEND_OS;
            SEND_OS:    if (cnt_send == SEND_LAST) state_d = END_WAIT;
            END_WAIT:   if (!tx_busy) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (start) begin
            state_d = LOAD_CW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt_word    <= '0;
            n_words     <= '0;
            cnt_pause   <= '0;
            cnt_timeout <= '0;
            cnt_send    <= '0;
            word_q      <= '0;
            perr_q      <= 1'b0;
            msg_error   <= 1'b0;
            tx_data     <= '0;
            tx_cd       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_d;
            done  <= (state == END_WAIT) && !tx_busy && !start;
            if (start) begin
                cnt_word    <= '0;
                cnt_pause   <= '0;
                cnt_timeout <= '0;
                cnt_send    <= '0;
                msg_error   <= 1'b0;
            end else begin
                unique case (state)
                    LOAD_CW: begin
                        // A zero count field means a full 32-word block.
                        n_words   <= {rx_data[4:0] == 5'd0, rx_data[4:0]};
                        msg_error <= msg_error | p_error;
                    end
                    WAIT_WORD: begin
                        if (rx_valid && rx_cd) begin
                            word_q      <= rx_data;
                            perr_q      <= p_error;
                            cnt_timeout <= '0;
                        end else if (rx_valid || timeout_hit) begin
                            msg_error <= 1'b1;
                        end else begin
                            cnt_timeout <= cnt_timeout + 16'd1;
                        end
                    end
                    STORE: begin
                        cnt_word  <= cnt_word + 6'd1;
                        msg_error <= msg_error | perr_q;
                        cnt_pause <= '0;
                    end
                    PAUSE_WAIT: cnt_pause <= cnt_pause + 16'd1;
                    LOAD_OS: begin
                        tx_data <= '0;
                        tx_data[RESP_ADDR_MSB:RESP_ADDR_LSB] <= ADDRESS;
                        tx_data[RESP_ERR_BIT] <= msg_error;
                        tx_cd    <= 1'b0;
                        cnt_send <= '0;
                    end
                    SEND_OS: cnt_send <= cnt_send + 2'd1;
                    default: ;
                endcase
            end
        end
    end

    rx_word_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (cnt_word[4:0]),
        .wdata (word_q),
        .raddr (addr_rd),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_device_rx.sv
// Randomized bench for device_rx against a transaction-level model:
// expected RAM image, response word and handshake counts per message.
module tb_device_rx;

    localparam logic [4:0] ADDR  = 5'd1;
    localparam int         PAUSE = 10;
    localparam int         TMO   = 40;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_cd;
    logic        p_error;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_busy;
    logic [4:0]  addr_rd;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        msg_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] ref_mem [32];
    bit          ref_ok  [32];
    logic [15:0] wbuf    [32];
    bit          pbuf    [32];

    device_rx #(
        .ADDRESS        (ADDR),
        .PAUSE_CYCLES   (PAUSE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_cd     (rx_cd),
        .p_error   (p_error),
        .tx_data   (tx_data),
        .tx_cd     (tx_cd),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .addr_rd   (addr_rd),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .msg_error (msg_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_cd"}, tx_cd, 0);
        check({tag, "_tx_ready"}, tx_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_msg_error"}, msg_error, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic fill_rand(input int perr_one_in);
        for (int i = 0; i < 32; i++) begin
            wbuf[i] = 16'($urandom);
            pbuf[i] = ($urandom_range(0, perr_one_in - 1) == 0);
        end
    endtask

    // kind: 0 normal, 1 command-word abort, 2 timeout,
    //       3 reset while waiting for a word, 4 reset during tx_ready
    task automatic run_txn(input logic [4:0] n_cmd, input int nw,
                           input bit cmd_perr, input int kind,
                           input int hold_in);
        int hold, wait_cyc, rdy, rdy_busy, dn, enc_left, enc_state;
        bit exp_err, seen, chk_rdw;
        logic [15:0] old0, txd;
        logic txcd;
        time t_last, t_rdy;
        hold = hold_in; exp_err = cmd_perr; seen = 0;
        rdy = 0; rdy_busy = 0; dn = 0; enc_left = 0; enc_state = 0;
        txd = '0; txcd = 1'b1; t_last = 0; t_rdy = 0; wait_cyc = 0;
        chk_rdw = ref_ok[0] && nw > 1;
        old0 = ref_mem[0];
        @(negedge clk);
        addr_rd = 5'd0; start = 1;
        rx_data = {11'($urandom), n_cmd}; p_error = cmd_perr;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rx_data = 16'($urandom); p_error = 0;
        for (int i = 0; i < nw; i++) begin
            if (i > 0) @(negedge clk);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            rx_valid = 1; rx_cd = 1; rx_data = wbuf[i]; p_error = pbuf[i];
            @(negedge clk);
            rx_valid = 0; p_error = 0;
            t_last = $time;
            ref_mem[i] = wbuf[i]; ref_ok[i] = 1; exp_err |= pbuf[i];
            if (i == 0 && chk_rdw) begin
                @(negedge clk);
                check("rdw_old", rd_data, old0);
                @(negedge clk);
                check("rdw_new", rd_data, wbuf[0]);
            end
        end
        if (kind == 1) begin
            @(negedge clk);
            rx_valid = 1; rx_cd = 0; rx_data = 16'($urandom);
            @(negedge clk);
            rx_valid = 0; rx_cd = 1; exp_err = 1;
        end else if (kind == 3) begin
            @(negedge clk);
            @(negedge clk);
            reset = 1;
            @(negedge clk);
            reset = 0;
            check_idle_outputs("rst_wait");
        end else if (kind != 2) begin
            @(negedge clk);
            @(negedge clk);
            rx_valid = 1; rx_data = 16'($urandom);
            @(negedge clk);
            rx_valid = 0;
            if (hold > 0) tx_busy = 1;
        end
        if (kind != 3) begin
            wait_cyc = 1;
            while (busy && wait_cyc < 3000) begin
                @(negedge clk);
                wait_cyc++;
                if (tx_ready && kind == 4) begin
                    reset = 1;
                    @(negedge clk);
                    reset = 0;
                    check_idle_outputs("rst_send");
                    break;
                end
                if (tx_ready) begin
                    rdy++;
                    if (tx_busy) rdy_busy++;
                    if (!seen) begin
                        seen = 1; txd = tx_data; txcd = tx_cd; t_rdy = $time;
                    end
                end
                if (done) dn++;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) tx_busy = 0;
                end
                if (seen && !tx_ready && enc_state == 0) begin
                    tx_busy = 1; enc_left = 4; enc_state = 1;
                end else if (enc_state == 1) begin
                    enc_left--;
                    if (enc_left == 0) begin
                        tx_busy = 0; enc_state = 2;
                    end
                end
            end
            @(negedge clk);
            if (done) dn++;
            check("busy_end", busy, 0);
            check("done_cnt", dn, (kind == 0) ? 1 : 0);
            if (kind == 0) begin
                check("resp_word", txd, {ADDR, exp_err, 10'd0});
                check("resp_cd", txcd, 0);
                check("ready_cycles", rdy, 3);
                check("ready_while_busy", rdy_busy, 0);
                check("msg_error", msg_error, exp_err);
                if (hold_in == 0)
                    check("ready_latency", 32'((t_rdy - t_last) / 10), PAUSE + 4);
            end
            if (kind == 1 || kind == 2) begin
                check("abort_ready", rdy, 0);
                check("abort_err", msg_error, 1);
            end
            if (kind == 2)
                check("timeout_cycles", wait_cyc, TMO + 2);
        end
        tx_busy = 0;
        for (int a = 0; a < 32; a++) begin
            if (ref_ok[a]) begin
                @(negedge clk);
                addr_rd = 5'(a);
                @(negedge clk);
                check($sformatf("ram[%0d]", a), rd_data, ref_mem[a]);
            end
        end
    endtask

    initial begin
        logic [4:0] n;
        clk = 0; reset = 1; start = 0; rx_data = '0; rx_valid = 0;
        rx_cd = 0; p_error = 0; tx_busy = 0; addr_rd = '0;
        for (int a = 0; a < 32; a++) begin
            ref_ok[a] = 0; ref_mem[a] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 0;

        wbuf[0] = 16'hA5A5; wbuf[1] = 16'h1234; wbuf[2] = 16'hFFFF;
        pbuf[0] = 0; pbuf[1] = 0; pbuf[2] = 0;
        run_txn(5'd3, 3, 0, 0, 0);

        fill_rand(1000);
        for (int i = 0; i < 32; i++) pbuf[i] = 0;
        run_txn(5'd0, 32, 0, 0, 0);

        fill_rand(1000);
        pbuf[0] = 0; pbuf[1] = 1;
        run_txn(5'd2, 2, 0, 0, 0);

        fill_rand(1000);
        pbuf[0] = 0; pbuf[1] = 0;
        run_txn(5'd4, 2, 0, 2, 0);

        fill_rand(1000);
        pbuf[0] = 0;
        run_txn(5'd3, 1, 0, 1, 0);

        fill_rand(1000);
        pbuf[0] = 0; pbuf[1] = 0; pbuf[2] = 0;
        run_txn(5'd3, 3, 0, 0, 50);

        fill_rand(1000);
        pbuf[0] = 0;
        run_txn(5'd3, 1, 1, 3, 0);

        fill_rand(1000);
        pbuf[0] = 1;
        run_txn(5'd1, 1, 0, 4, 0);

        repeat (8) begin
            n = 5'($urandom);
            fill_rand(8);
            run_txn(n, (n == 0) ? 32 : int'(n), $urandom_range(0, 9) == 0, 0,
                    $urandom_range(0, 1) ? int'($urandom_range(1, 30)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/device_rx.md
DEVICE_RX -- requirements
Module: device_rx

Interface
REQ-001 Parameter ADDRESS, default 5'd1, remote-terminal address placed in response word bits [15:11].
REQ-002 Parameter PAUSE_CYCLES, default 255, clk cycles between last data word and response word load.
REQ-003 Parameter TIMEOUT_CYCLES, default 1023, maximum clk cycles allowed between consecutive data words.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle strobe; receive command word present on rx_data.
REQ-007 rx_data  in  16  decoded word from the RX decoder.
REQ-008 rx_valid  in  1  one-cycle strobe; rx_data, rx_cd and p_error valid.
REQ-009 rx_cd  in  1  1 = data word, 0 = command word.
REQ-010 p_error  in  1  parity/Manchester error for the current word.
REQ-011 tx_data  out  16  word to the TX encoder.
REQ-012 tx_cd  out  1  0 = response/command sync, 1 = data sync.
REQ-013 tx_ready  out  1  send request to the encoder.
REQ-014 tx_busy  in  1  encoder currently transmitting.
REQ-015 addr_rd  in  5  host read address of the received-word RAM.
REQ-016 rd_data  out  16  host read data, registered.
REQ-017 busy  out  1  transaction in progress.
REQ-018 done  out  1  one-cycle pulse on normal completion.
REQ-019 msg_error  out  1  sticky error of the last transaction; cleared by the next start.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD_CW, WAIT_WORD, STORE, PAUSE_WAIT, LOAD_OS, SEND_WAIT, SEND_OS and END_WAIT.
REQ-021 start in any state SHALL force LOAD_CW on the next edge, clearing the word counter, the pause/timeout counters and msg_error, and setting busy=1.
REQ-022 LOAD_CW SHALL latch N=rx_data[4:0], where N=0 means 32 words, set msg_error if p_error=1, and go to WAIT_WORD.
REQ-023 In WAIT_WORD, rx_valid with rx_cd=1 SHALL go to STORE; the timeout counter resets on each accepted word.
REQ-024 In STORE, the word SHALL be written to RAM[cnt_word], p_error=1 SHALL set msg_error (the word is still stored and counted), and cnt_word SHALL increment.
REQ-025 After STORE, the FSM SHALL go to PAUSE_WAIT if cnt_word equals the word count (N, or 32 when N=0); otherwise it returns to WAIT_WORD.
REQ-026 rx_valid with rx_cd=0 in WAIT_WORD SHALL abort: msg_error=1, no response word, next state IDLE, done stays 0.
REQ-027 If no word is accepted within TIMEOUT_CYCLES in WAIT_WORD, the block SHALL abort exactly as in REQ-026.
REQ-028 The word counter SHALL be 6 bits wide, so that 32 is representable; RAM write addresses SHALL use bits [4:0].
REQ-029 PAUSE_WAIT SHALL count PAUSE_CYCLES+1 cycles, then go to LOAD_OS.
REQ-030 LOAD_OS SHALL set tx_data={ADDRESS, msg_error, 10'd0} and tx_cd=0.
REQ-031 SEND_WAIT SHALL hold while tx_busy=1.
REQ-032 SEND_OS SHALL hold tx_ready=1 for exactly 3 cycles, then drop it and go to END_WAIT.
REQ-033 END_WAIT SHALL wait for tx_busy=0, then pulse done=1 for one cycle and go to IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 rd_data SHALL equal RAM[addr_rd] with a 1-cycle latency.
REQ-036 A host read of the address being written in the same cycle SHALL return the old data.
REQ-037 RAM contents SHALL persist across transactions and reset; only words received in the current transaction are overwritten.
REQ-038 rx_valid outside WAIT_WORD SHALL be ignored.

Reset
REQ-039 reset SHALL have priority over start.
REQ-040 On reset: state=IDLE; tx_data=0, tx_cd=0, tx_ready=0, busy=0, done=0, msg_error=0; all counters=0; rd_data=0.
REQ-041 reset asserted mid-transaction SHALL drop tx_ready on the next edge and produce no done pulse.

Structure
REQ-042 A shared package SHALL hold the FSM state enum, the response-word field positions (address [15:11], message-error bit 10) and the tx_ready pulse length constant (3).
REQ-043 The 32x16 RAM with one write port and one registered read port SHALL be the single sub-module, named rx_word_ram.

Verification
REQ-044 Scenario: start with rx_data[4:0]=3, then 3 clean data words 0xA5A5/0x1234/0xFFFF → RAM[0..2] holds them, tx_data=0x0800, msg_error=0, done pulses once.
REQ-045 Scenario: N=0, then 32 data words → all 32 stored, exactly 32 STORE cycles, response word sent.
REQ-046 Scenario: N=2, second word arrives with p_error=1 → both words stored, response 0x0C00, msg_error=1.
REQ-047 Scenario: N=4, only 2 words, then silence → timeout after TIMEOUT_CYCLES, no tx_ready, busy=0, msg_error=1.
REQ-048 Scenario: N=3, a command word (rx_cd=0) after the first word → abort, no response, msg_error=1.
REQ-049 Scenario: tx_busy held high 50 cycles at SEND_WAIT, then reset pulsed mid-WAIT_WORD on a new transaction → tx_ready waits for tx_busy to drop and is high for 3 cycles; after reset all outputs are at their reset values.
